// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states and the latched request bundle.
package rv32i_types;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } mem_arb_state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byte_enable;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // A request carrying both strobes is treated as a write.
    function automatic mem_req_t normalize_req(input logic              read,
                                               input logic              write,
                                               input logic [ADDR_W-1:0] address,
                                               input logic [BE_W-1:0]   byte_enable,
                                               input logic [DATA_W-1:0] wdata);
        mem_req_t req;
        req.read        = read & ~write;
        req.write       = write;
        req.address     = address;
        req.byte_enable = byte_enable;
        req.wdata       = wdata;
        return req;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// Loadable holding register for the winning request; keeps downstream signals stable while busy.
module arb_req_latch
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_load,
    input  mem_req_t i_req,
    output mem_req_t o_req
);

    mem_req_t r_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (i_load) begin
            r_req <= i_req;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between I-side and D-side requesters.
// D wins by default; a streak counter forces an I grant after MAX_D_STREAK D grants while I waits.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [BE_W-1:0]   i_byte_enable,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byte_enable,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned          STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    mem_arb_state_t      r_state;
    mem_arb_state_t      w_state_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;

    logic     w_i_req;
    logic     w_d_req;
    logic     w_load;
    logic     w_busy;
    mem_req_t w_i_side;
    mem_req_t w_d_side;
    mem_req_t w_load_req;
    mem_req_t w_latched;

    assign w_i_req  = i_read | i_write;
    assign w_d_req  = d_read | d_write;
    assign w_i_side = normalize_req(i_read, i_write, i_address, i_byte_enable, i_wdata);
    assign w_d_side = normalize_req(d_read, d_write, d_address, d_byte_enable, d_wdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        w_load        = 1'b0;
        w_load_req    = w_d_side;
        case (r_state)
            IDLE: begin
                if (w_d_req && (!w_i_req || (r_streak < STREAK_MAX))) begin
                    w_load       = 1'b1;
                    w_load_req   = w_d_side;
                    w_state_next = BUSY_D;
                    // Only D grants that bypass a waiting I request count toward the streak.
                    if (w_i_req) begin
                        w_streak_next = (r_streak == STREAK_MAX) ? r_streak
                                                                 : r_streak + STREAK_W'(1);
                    end else begin
                        w_streak_next = '0;
                    end
                end else if (w_i_req) begin
                    w_load        = 1'b1;
                    w_load_req    = w_i_side;
                    w_state_next  = BUSY_I;
                    w_streak_next = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    arb_req_latch u_req_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_req  (w_load_req),
        .o_req  (w_latched)
    );

    // Downstream port is silent in IDLE and reflects only the latched request while busy.
    assign w_busy          = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign mem_read        = w_busy & w_latched.read;
    assign mem_write       = w_busy & w_latched.write;
    assign mem_address     = w_busy ? w_latched.address     : '0;
    assign mem_byte_enable = w_busy ? w_latched.byte_enable : '0;
    assign mem_wdata       = w_busy ? w_latched.wdata       : '0;

    assign i_resp  = (r_state == BUSY_I) & mem_resp;
    assign d_resp  = (r_state == BUSY_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
